// File: rtl/board_loader.sv
// board_loader: serial-in Game of Life board loader, one row write per WIDTH accepted bits.
// Optional macro LOAD_PARITY_EN adds a per-row even-parity bit and a sticky err flag.
module board_loader #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               start,
    input  logic               sin,
    input  logic               sin_valid,
    output logic               sin_ready,
    output logic               we,
    output logic [REGBITS-1:0] waddr,
    output logic [WIDTH-1:0]   wd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CBITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CBITS-1:0]   LAST_BIT = CBITS'(WIDTH - 1);
    localparam logic [REGBITS-1:0] LAST_ROW = '1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PAR,
        WRITE,
        DONE
    } state_t;

    state_t             state;
    logic [REGBITS-1:0] row;
    logic [CBITS-1:0]   bitcnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shnext;
    logic               take;

    assign take   = sin_valid & sin_ready;
    assign shnext = {shreg[WIDTH-2:0], sin};

`ifdef LOAD_PARITY_EN
    logic perr;
    assign err = perr;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge ph1) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            sin_ready <= 1'b0;
            we        <= 1'b0;
            waddr     <= '0;
            wd        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef LOAD_PARITY_EN
            perr      <= 1'b0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        sin_ready <= 1'b1;
                        busy      <= 1'b1;
                        row       <= '0;
                        bitcnt    <= '0;
`ifdef LOAD_PARITY_EN
                        perr      <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (take) begin
                        shreg <= shnext;
                        if (bitcnt == LAST_BIT) begin
                            bitcnt <= '0;
`ifdef LOAD_PARITY_EN
                            state  <= PAR;
`else
                            state     <= WRITE;
                            sin_ready <= 1'b0;
                            we        <= 1'b1;
                            waddr     <= row;
                            wd        <= shnext;
`endif
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                PAR: begin
`ifdef LOAD_PARITY_EN
                    // even parity over the row bits plus the parity bit
                    if (take) begin
                        if (^{shreg, sin}) perr <= 1'b1;
                        state     <= WRITE;
                        sin_ready <= 1'b0;
                        we        <= 1'b1;
                        waddr     <= row;
                        wd        <= shreg;
                    end
`else
                    state <= IDLE;
`endif
                end
                WRITE: begin
                    if (row == LAST_ROW) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        row       <= row + 1'b1;
                        state     <= SHIFT;
                        sin_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_loader.sv
// tb_board_loader: randomized self-checking bench for board_loader.
// Expected rows, write order and cycle timing come from a row-level model.
module tb_board_loader;

    localparam int W    = 8;
    localparam int RB   = 3;
    localparam int ROWS = 1 << RB;
`ifdef LOAD_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int P = W + 1 + PB;

    logic          ph1 = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          sin = 1'b0;
    logic          sin_valid = 1'b0;
    logic          sin_ready;
    logic          we;
    logic [RB-1:0] waddr;
    logic [W-1:0]  wd;
    logic          busy;
    logic          done;
    logic          err;

    board_loader #(.WIDTH(W), .REGBITS(RB)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .start     (start),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .we        (we),
        .waddr     (waddr),
        .wd        (wd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 ph1 = ~ph1;

    int checks = 0;
    int failures = 0;

    int   cyc = 0;
    int   shift_cyc = 0;
    int   idle_cyc = 0;
    int   acc_since = 0;
    logic busy_q = 1'b0;

    int          wa_q[$];
    int          wc_q[$];
    int          wn_q[$];
    int          wx_q[$];
    int          dc_q[$];
    logic [W-1:0] wd_q[$];

    logic [W-1:0] rows[ROWS];
`ifdef LOAD_PARITY_EN
    logic par[ROWS];
`endif

    // event log sampled on the falling edge, away from DUT updates
    always @(negedge ph1) begin
        cyc    <= cyc + 1;
        busy_q <= busy;
        if (busy === 1'b1 && busy_q === 1'b0) shift_cyc <= cyc;
        if (busy === 1'b0 && busy_q === 1'b1) idle_cyc <= cyc;
        if (we === 1'b1) begin
            wa_q.push_back(int'(waddr));
            wd_q.push_back(wd);
            wc_q.push_back(cyc);
            wn_q.push_back(acc_since);
            wx_q.push_back(int'(sin_valid && sin_ready));
            acc_since <= 0;
        end else if (start && busy === 1'b0) begin
            acc_since <= 0;
        end else if (sin_valid && sin_ready === 1'b1) begin
            acc_since <= acc_since + 1;
        end
        if (done === 1'b1) dc_q.push_back(cyc);
    end

    task automatic drive_load(input int mode, output int sent);
        logic stream[$];
        int   budget;
        logic phase;
        for (int r = 0; r < ROWS; r++) begin
            for (int b = W - 1; b >= 0; b--) stream.push_back(rows[r][b]);
`ifdef LOAD_PARITY_EN
            stream.push_back(par[r]);
`endif
        end
        @(posedge ph1); #1;
        start = 1'b1;
        sin_valid = 1'b0;
        @(posedge ph1); #1;
        start = 1'b0;
        sent = 0;
        budget = 0;
        phase = 1'b1;
        while (sent < stream.size() && budget < 4000) begin
            sin = stream[sent];
            if (mode == 0) sin_valid = 1'b1;
            else if (mode == 1) sin_valid = phase;
            else sin_valid = 1'($urandom_range(0, 1));
            @(negedge ph1);
            if (sin_valid && sin_ready === 1'b1) sent++;
            @(posedge ph1); #1;
            phase = ~phase;
            budget++;
        end
        sin_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit got);
        for (int i = 0; i < 300 && dc_q.size() == d0; i++) @(negedge ph1);
        got = (dc_q.size() > d0);
    endtask

    task automatic set_pattern();
        rows = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
`ifdef LOAD_PARITY_EN
        for (int r = 0; r < ROWS; r++) par[r] = ^rows[r];
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge ph1);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ph1);
            checks++;
            if ({sin_ready, we, busy, done, err} !== 5'b0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d got %b want 00000", i,
                         {sin_ready, we, busy, done, err});
            end
        end
        checks++;
        if (waddr !== '0 || wd !== '0) begin
            failures++;
            $display("FAIL reset_regs got waddr=%0d wd=%h want 0/00", waddr, wd);
        end
    endtask

    task automatic test_stream();
        int w0, d0, sent;
        bit got;
        set_pattern();
        w0 = wa_q.size();
        d0 = dc_q.size();
        drive_load(0, sent);
        checks++;
        if (sent != ROWS * (W + PB)) begin
            failures++;
            $display("FAIL stream_sent got %0d want %0d", sent, ROWS * (W + PB));
        end
        wait_done(d0, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL stream_done_timeout got none want done pulse");
        end
        repeat (3) @(negedge ph1);
        checks++;
        if (wa_q.size() - w0 != ROWS) begin
            failures++;
            $display("FAIL stream_nwrites got %0d want %0d", wa_q.size() - w0, ROWS);
        end else begin
            for (int k = 0; k < ROWS; k++) begin
                checks++;
                if (wa_q[w0+k] != k || wd_q[w0+k] !== rows[k]) begin
                    failures++;
                    $display("FAIL stream_row%0d got %0d/%h want %0d/%h", k,
                             wa_q[w0+k], wd_q[w0+k], k, rows[k]);
                end
                checks++;
                if (wc_q[w0+k] - shift_cyc != k * P + P - 1) begin
                    failures++;
                    $display("FAIL stream_we_time%0d got %0d want %0d", k,
                             wc_q[w0+k] - shift_cyc, k * P + P - 1);
                end
            end
        end
        if (got) begin
            checks++;
            if (dc_q[d0] - shift_cyc != P * ROWS) begin
                failures++;
                $display("FAIL stream_done_time got %0d want %0d",
                         dc_q[d0] - shift_cyc, P * ROWS);
            end
            checks++;
            if (dc_q.size() - d0 != 1) begin
                failures++;
                $display("FAIL stream_done_pulses got %0d want 1", dc_q.size() - d0);
            end
            checks++;
            if (idle_cyc - dc_q[d0] != 1) begin
                failures++;
                $display("FAIL stream_busy_fall got %0d want 1", idle_cyc - dc_q[d0]);
            end
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got busy=%b err=%b want 0/0", busy, err);
        end
    endtask

    task automatic test_throttled(input int mode);
        int w0, d0, sent;
        bit got;
        set_pattern();
        if (mode == 2) begin
            for (int r = 0; r < ROWS; r++) begin
                rows[r] = W'($urandom);
`ifdef LOAD_PARITY_EN
                par[r] = ^rows[r];
`endif
            end
        end
        w0 = wa_q.size();
        d0 = dc_q.size();
        drive_load(mode, sent);
        checks++;
        if (sent != ROWS * (W + PB)) begin
            failures++;
            $display("FAIL thr%0d_sent got %0d want %0d", mode, sent, ROWS * (W + PB));
        end
        wait_done(d0, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL thr%0d_done_timeout got none want done pulse", mode);
        end
        repeat (3) @(negedge ph1);
        checks++;
        if (wa_q.size() - w0 != ROWS) begin
            failures++;
            $display("FAIL thr%0d_nwrites got %0d want %0d", mode, wa_q.size() - w0, ROWS);
        end else begin
            for (int k = 0; k < ROWS; k++) begin
                checks++;
                if (wa_q[w0+k] != k || wd_q[w0+k] !== rows[k]) begin
                    failures++;
                    $display("FAIL thr%0d_row%0d got %0d/%h want %0d/%h", mode, k,
                             wa_q[w0+k], wd_q[w0+k], k, rows[k]);
                end
                checks++;
                if (wn_q[w0+k] != W + PB || wx_q[w0+k] != 0) begin
                    failures++;
                    $display("FAIL thr%0d_bits%0d got %0d acc_in_write=%0d want %0d/0",
                             mode, k, wn_q[w0+k], wx_q[w0+k], W + PB);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL thr%0d_end got busy=%b err=%b want 0/0", mode, busy, err);
        end
    endtask

    task automatic test_restart_reset();
        int w0, d0, expn;
        w0 = wa_q.size();
        d0 = dc_q.size();
        expn = 0;
        for (int k = 0; k < ROWS; k++) if (k * P + P - 1 <= 30) expn++;
        @(posedge ph1); #1;
        start = 1'b1;
        @(posedge ph1); #1;
        start = 1'b0;
        for (int i = 0; i < 140; i++) begin
            start = (i == 20);
            reset = (i == 30 || i == 31);
            sin_valid = 1'b1;
            sin = 1'($urandom_range(0, 1));
            @(negedge ph1);
            if (i >= 31) begin
                checks++;
                if ({busy, we, done, sin_ready} !== 4'b0) begin
                    failures++;
                    $display("FAIL abort_idle cycle %0d got %b want 0000", i,
                             {busy, we, done, sin_ready});
                end
            end
            @(posedge ph1); #1;
        end
        start = 1'b0;
        reset = 1'b0;
        sin_valid = 1'b0;
        checks++;
        if (wa_q.size() - w0 != expn) begin
            failures++;
            $display("FAIL abort_nwrites got %0d want %0d", wa_q.size() - w0, expn);
        end else begin
            for (int k = 0; k < expn; k++) begin
                checks++;
                if (wa_q[w0+k] != k || wc_q[w0+k] - shift_cyc != k * P + P - 1) begin
                    failures++;
                    $display("FAIL abort_row%0d got addr=%0d t=%0d want %0d/%0d", k,
                             wa_q[w0+k], wc_q[w0+k] - shift_cyc, k, k * P + P - 1);
                end
            end
        end
        checks++;
        if (idle_cyc - shift_cyc != 31) begin
            failures++;
            $display("FAIL abort_busy_span got %0d want 31", idle_cyc - shift_cyc);
        end
        checks++;
        if (dc_q.size() != d0) begin
            failures++;
            $display("FAIL abort_done got %0d pulses want 0", dc_q.size() - d0);
        end
        checks++;
        if (waddr !== '0 || wd !== '0) begin
            failures++;
            $display("FAIL abort_regs got %0d/%h want 0/00", waddr, wd);
        end
    endtask

`ifdef LOAD_PARITY_EN
    task automatic test_parity();
        int w0, d0, sent;
        bit got;
        for (int r = 0; r < ROWS; r++) begin
            rows[r] = 8'h07;
            par[r] = 1'b1;
        end
        d0 = dc_q.size();
        drive_load(0, sent);
        wait_done(d0, got);
        @(negedge ph1);
        checks++;
        if (!got || err !== 1'b0) begin
            failures++;
            $display("FAIL par_good got done=%0d err=%b want 1/0", got, err);
        end
        par[0] = 1'b0;
        w0 = wa_q.size();
        d0 = dc_q.size();
        drive_load(0, sent);
        wait_done(d0, got);
        @(negedge ph1);
        checks++;
        if (!got || err !== 1'b1) begin
            failures++;
            $display("FAIL par_bad got done=%0d err=%b want 1/1", got, err);
        end
        checks++;
        if (wa_q.size() - w0 != ROWS || wa_q[w0] != 0 || wd_q[w0] !== 8'h07) begin
            failures++;
            $display("FAIL par_bad_write got n=%0d want %0d row0=07", wa_q.size() - w0, ROWS);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ph1);
            checks++;
            if (err !== 1'b1) begin
                failures++;
                $display("FAIL par_sticky cycle %0d got %b want 1", i, err);
            end
        end
        @(posedge ph1); #1;
        start = 1'b1;
        @(posedge ph1); #1;
        start = 1'b0;
        @(negedge ph1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL par_clear got err=%b busy=%b want 0/1", err, busy);
        end
        @(posedge ph1); #1;
        reset = 1'b1;
        repeat (2) @(posedge ph1);
        #1 reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_throttled(1);
        test_throttled(2);
        test_restart_reset();
`ifdef LOAD_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
